// File: rtl/reg_ctrl_pkg.sv
// Shared types and default sizes for the shared-register write arbiter.
package reg_ctrl_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_NUM_REQ = 4;

endpackage

// File: rtl/reg_wr_arbiter_w16_if.sv
// Requester-side bus of the shared-register arbiter plus the register/status view.
// Handshake: a write transfers from requester i at a rising edge where req_valid[i]
// and req_ready[i] are both high; req_data/req_lock are sampled only at that edge,
// and a requester may drop req_valid without a transfer at no cost.
interface reg_wr_arbiter_w16_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_lock;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]         reg_q;
  logic [IDX_W-1:0]         reg_owner;
  logic                     wr_pulse;
  logic [15:0]              wr_count;
  logic                     locked;

  modport master (
    output req_valid, req_lock, req_data,
    input  req_ready, reg_q, reg_owner, wr_pulse, wr_count, locked
  );

  modport slave (
    input  req_valid, req_lock, req_data,
    output req_ready, reg_q, reg_owner, wr_pulse, wr_count, locked
  );
endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first requester at or after ptr_i, searching upward modulo N.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/reg_wr_arbiter_w16.sv
// Round-robin arbiter granting NUM_REQ requesters write access to one shared
// register, with per-requester burst locking; the locked output is the FSM state view.
module reg_wr_arbiter_w16
  import reg_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_wr_arbiter_w16_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   lock_id_q, lock_id_d;
  logic [WIDTH-1:0]   data_q;
  logic [IDX_W-1:0]   owner_q;
  logic               pulse_q;
  logic [15:0]        count_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic [NUM_REQ-1:0] ready_c;
  logic               fire;
  logic [IDX_W-1:0]   xfer_idx;
  logic [WIDTH-1:0]   xfer_data;

  function automatic logic [IDX_W-1:0] inc_mod(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_id_d = lock_id_q;
    ready_c   = '0;
    fire      = 1'b0;
    xfer_idx  = pick_idx;
    case (state_q)
      ARB: begin
        ready_c  = pick_gnt;
        fire     = pick_any;
        xfer_idx = pick_idx;
        if (pick_any) begin
          ptr_d = inc_mod(pick_idx);
          if (bus.req_lock[pick_idx]) begin
            state_d   = LOCKED;
            lock_id_d = pick_idx;
          end
        end
      end
      LOCKED: begin
        xfer_idx           = lock_id_q;
        fire               = bus.req_valid[lock_id_q];
        ready_c[lock_id_q] = bus.req_valid[lock_id_q];
        // Leave the burst when the owner goes idle or sends its unlocked last beat.
        if (!bus.req_valid[lock_id_q] || !bus.req_lock[lock_id_q]) begin
          state_d = ARB;
          ptr_d   = inc_mod(lock_id_q);
        end
      end
      default: state_d = ARB;
    endcase
    if (rst) begin
      ready_c = '0;
      fire    = 1'b0;
    end
  end

  always_comb begin
    xfer_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer_idx == IDX_W'(i)) xfer_data = bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB;
      ptr_q     <= '0;
      lock_id_q <= '0;
      data_q    <= '0;
      owner_q   <= '0;
      pulse_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_id_q <= lock_id_d;
      pulse_q   <= fire;
      if (fire) begin
        data_q  <= xfer_data;
        owner_q <= xfer_idx;
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.reg_q     = data_q;
  assign bus.reg_owner = owner_q;
  assign bus.wr_pulse  = pulse_q;
  assign bus.wr_count  = count_q;
  assign bus.locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_reg_wr_arbiter_w16.sv
// Directed bench for reg_wr_arbiter_w16: reset, single write, round robin,
// lock burst, reset mid-burst and write-counter wrap.
module tb_reg_wr_arbiter_w16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_wr_arbiter_w16_if #(.WIDTH(16), .NUM_REQ(4)) bus ();

  reg_wr_arbiter_w16 #(.WIDTH(16), .NUM_REQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [15:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] v, input logic [3:0] l,
                       input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] d2, input logic [15:0] d3);
    bus.req_valid = v;
    bus.req_lock  = l;
    bus.req_data  = {d3, d2, d1, d0};
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [15:0] q, input logic [1:0] own,
                         input logic pulse, input logic [15:0] cnt, input logic lk);
    chk({tag, "_reg_q"},  32'(bus.reg_q),     32'(q));
    chk({tag, "_owner"},  32'(bus.reg_owner), 32'(own));
    chk({tag, "_pulse"},  32'(bus.wr_pulse),  32'(pulse));
    chk({tag, "_count"},  32'(bus.wr_count),  32'(cnt));
    chk({tag, "_locked"}, 32'(bus.locked),    32'(lk));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    drive(4'hF, 4'h0, 16'h1, 16'h2, 16'h3, 16'h4);
    @(negedge clk);
    chk("rst_ready_a", 32'(bus.req_ready), 32'h0);
    tick();
    chk("rst_ready_b", 32'(bus.req_ready), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    #1;
    chk_reg("after_rst", 16'h0, 2'd0, 1'b0, 16'd0, 1'b0);

    // single write from requester 2
    drive(4'b0100, 4'h0, 16'h0, 16'h0, 16'h0005, 16'h0);
    #1 chk("single_ready", 32'(bus.req_ready), 32'b0100);
    tick();
    chk_reg("single", 16'h0005, 2'd2, 1'b1, 16'd1, 1'b0);

    // requester 3 write moves the pointer back to 0
    drive(4'b1000, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0033);
    #1 chk("r3_ready", 32'(bus.req_ready), 32'b1000);
    tick();
    chk_reg("r3", 16'h0033, 2'd3, 1'b1, 16'd2, 1'b0);

    // idle cycle: pulse drops, register holds
    drive(4'h0, 4'h0, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD);
    tick();
    chk_reg("idle", 16'h0033, 2'd3, 1'b0, 16'd2, 1'b0);

    // round robin with all four valid
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
    drive(4'hF, 4'h0, 16'h000A, 16'h000B, 16'h000C, 16'h000D);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      #1 chk("rr_ready", 32'(bus.req_ready), 32'(1) << e);
      tick();
      chk("rr_owner", 32'(bus.reg_owner), 32'(e));
      chk("rr_reg_q", 32'(bus.reg_q), 32'h000A + 32'(e));
    end
    chk_reg("rr_end", 16'h000D, 2'd3, 1'b1, 16'd6, 1'b0);

    // requester 0 write sets ptr to 1
    drive(4'b0001, 4'h0, 16'h000E, 16'h0, 16'h0, 16'h0);
    tick();
    chk_reg("r0", 16'h000E, 2'd0, 1'b1, 16'd7, 1'b0);

    // lock burst from requester 1 while requester 0 stays valid
    drive(4'b0011, 4'b0010, 16'h0F0F, 16'h1111, 16'h0, 16'h0);
    #1 chk("lk1_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    chk_reg("lk1", 16'h1111, 2'd1, 1'b1, 16'd8, 1'b1);
    drive(4'b0011, 4'b0010, 16'h0F0F, 16'h2222, 16'h0, 16'h0);
    #1 chk("lk2_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    chk_reg("lk2", 16'h2222, 2'd1, 1'b1, 16'd9, 1'b1);
    drive(4'b0011, 4'b0000, 16'h0F0F, 16'h3333, 16'h0, 16'h0);
    #1 chk("lk3_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    chk_reg("lk3", 16'h3333, 2'd1, 1'b1, 16'd10, 1'b0);

    // after the burst, ptr = 2: requester 2 beats requester 0
    drive(4'b0101, 4'h0, 16'h0F0F, 16'h0, 16'h2A2A, 16'h0);
    #1 chk("post_lock_ready", 32'(bus.req_ready), 32'b0100);
    tick();
    chk_reg("post_lock", 16'h2A2A, 2'd2, 1'b1, 16'd11, 1'b0);

    // ptr = 3, requester 3 idle: wrap to 0, which locks
    drive(4'b0101, 4'b0001, 16'h0B0B, 16'h0, 16'h2B2B, 16'h0);
    #1 chk("wrap_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    chk_reg("lock0", 16'h0B0B, 2'd0, 1'b1, 16'd12, 1'b1);

    // owner drops valid: leave LOCKED with no write
    drive(4'b0000, 4'b0001, 16'hBAD0, 16'h0, 16'h0, 16'h0);
    #1 chk("drop_ready", 32'(bus.req_ready), 32'b0000);
    tick();
    chk_reg("drop", 16'h0B0B, 2'd0, 1'b0, 16'd12, 1'b0);

    // reset in the second cycle of a burst
    drive(4'b0010, 4'b0010, 16'h0, 16'h4444, 16'h0, 16'h0);
    #1 chk("rl_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    chk_reg("rl1", 16'h4444, 2'd1, 1'b1, 16'd13, 1'b1);
    rst = 1'b1;
    drive(4'b0010, 4'b0010, 16'h0, 16'h5555, 16'h0, 16'h0);
    #1 chk("rl_rst_ready", 32'(bus.req_ready), 32'b0000);
    tick();
    rst = 1'b0;
    drive(4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    #1 chk_reg("rl_rst", 16'h0, 2'd0, 1'b0, 16'd0, 1'b0);

    // write counter wrap: 0xFFFF back-to-back writes, then one more
    drive(4'b0001, 4'h0, 16'h0077, 16'h0, 16'h0, 16'h0);
    repeat (65535) @(posedge clk);
    @(negedge clk);
    chk_reg("pre_wrap", 16'h0077, 2'd0, 1'b1, 16'hFFFF, 1'b0);
    drive(4'b0001, 4'h0, 16'h0078, 16'h0, 16'h0, 16'h0);
    tick();
    chk_reg("wrap", 16'h0078, 2'd0, 1'b1, 16'h0000, 1'b0);
    drive(4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    tick();

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_wr_arbiter_w16.md
REG_WR_ARBITER_W16 -- requirements
Module: reg_wr_arbiter_w16

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the data width of the shared register.
REQ-002 SHALL have parameter NUM_REQ, default 4, the number of requesters (2..8).
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, NUM_REQ: per-requester write request.
REQ-006 SHALL have port req_lock, input, NUM_REQ: per-requester burst-lock request, sampled with req_valid.
REQ-007 SHALL have port req_data, input, NUM_REQ*WIDTH: write data, where requester i uses bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_ready, output, NUM_REQ: one-hot-or-zero grant, combinational from state and req_valid.
REQ-009 SHALL have port reg_q, output, WIDTH: the shared register value.
REQ-010 SHALL have port reg_owner, output, clog2(NUM_REQ): index of the last requester that wrote reg_q.
REQ-011 SHALL have port wr_pulse, output, 1: high for exactly the cycles in which reg_q holds newly written data.
REQ-012 SHALL have port wr_count, output, 16: total accepted writes since reset.
REQ-013 SHALL have port locked, output, 1: high while the FSM is in LOCKED.

Function
REQ-014 SHALL define a transfer as req_valid[i] and req_ready[i] both high at a rising edge; at most one transfer occurs per cycle.
REQ-015 SHALL, on a transfer from i, load reg_q with req_data slice i, load reg_owner with i, assert wr_pulse, and increment wr_count, all on the same edge; reg_q is visible 1 cycle after the handshake.
REQ-016 SHALL deassert wr_pulse in every cycle that follows an edge without a transfer.
REQ-017 SHALL wrap wr_count from 0xFFFF to 0x0000.
REQ-018 SHALL have FSM states ARB and LOCKED.
REQ-019 SHALL, in ARB, grant the first valid requester at or after the round-robin pointer ptr, searching upward modulo NUM_REQ; with no valid requester, req_ready is 0.
REQ-020 SHALL, on a transfer from i in ARB, set ptr to (i+1) mod NUM_REQ.
REQ-021 SHALL, on a transfer from i in ARB with req_lock[i] high, move to LOCKED with lock_id = i.
REQ-022 SHALL, in LOCKED, set req_ready[lock_id] = req_valid[lock_id] and hold all other req_ready bits at 0.
REQ-023 SHALL return from LOCKED to ARB at an edge where req_valid[lock_id] is low, or where a transfer occurs with req_lock[lock_id] low; ptr = (lock_id+1) mod NUM_REQ on exit.
REQ-024 SHALL hold ptr constant in LOCKED.
REQ-025 SHALL leave reg_q, reg_owner and wr_count unchanged when req_valid falls without a transfer.

Reset
REQ-026 SHALL, when rst is high at a rising edge, set reg_q = 0, reg_owner = 0, wr_pulse = 0, wr_count = 0, ptr = 0, lock_id = 0 and the state to ARB, and discard any same-cycle transfer.
REQ-027 SHALL force req_ready to 0 while rst is high.
REQ-028 SHALL abandon a LOCKED burst when reset arrives mid-burst, with no partial write.

Structure
REQ-029 SHALL place the FSM state typedef (ARB, LOCKED) and default WIDTH/NUM_REQ constants in the shared package reg_ctrl_pkg.
REQ-030 SHALL implement round-robin selection as the sub-module rr_pick (inputs: request vector, ptr; outputs: grant one-hot, grant index, any).

Verification
REQ-031 SHALL cover reset: hold rst for 2 cycles with all req_valid high -> req_ready = 0, and after release reg_q = 0, wr_count = 0, locked = 0.
REQ-032 SHALL cover single write: req_valid = 0b0100 with slice 2 = 0x0005 -> req_ready = 0b0100, next cycle reg_q = 0x0005, reg_owner = 2, wr_pulse = 1, wr_count = 1.
REQ-033 SHALL cover round robin: all four valid for 4 cycles from ptr = 0, data = 0x000A/0x000B/0x000C/0x000D -> grants in order 0,1,2,3, final reg_q = 0x000D, wr_count = 4.
REQ-034 SHALL cover lock: requester 1 sends 3 writes (0x1111, 0x2222, 0x3333) with req_lock high on the first two while requester 0 is valid throughout -> requester 0 is not granted until after 0x3333 lands; locked falls; the next grant goes to 2 if valid, else 0.
REQ-035 SHALL cover reset mid-lock: rst in the second cycle of a LOCKED burst -> no write that cycle, state ARB, reg_q = 0.
REQ-036 SHALL cover count wrap: preload 0xFFFF writes (or force the counter), then one more transfer -> wr_count = 0x0000.
